video_ports_ml: RTL
===================

Name: video_ports_ml

Overview:
- Parametrised video-parameter latch bank for the TSConf video pipeline, successor to the fixed two-tile-layer port block.
- Takes CPU writes through one addressed write port instead of one strobe per register, and supports NLAYERS tile layers.
- Shadow registers update on write; active registers update at line start, or at frame start for Y offsets when YLATCH=1.
- Adds a configurable frame length for the VINT auto-increment wrap and an optional registered readback path.

Parameters:
- NLAYERS, 2, number of tile layers (1..4).
- OFFS_W, 9, X/Y scroll offset width (9..12); the high-byte write supplies bits OFFS_W-1:8 from d[OFFS_W-9:0].
- VLINES, 320, lines per frame; wrap modulus for vint_beg.
- YLATCH, 0, 0 = Y offsets take effect immediately; 1 = Y offsets are applied at int_start.

Ports:
- clk  in  1  system clock.
- res_n  in  1  synchronous reset, active low.
- d  in  8  CPU write data.
- wr  in  1  addressed write strobe, one cycle.
- wa  in  8  write address.
- zborder_wr  in  1  ZX-compatible border write.
- zvpage_wr  in  1  ZX-compatible screen page write.
- line_start_s  in  1  line-start pulse.
- int_start  in  1  frame interrupt pulse.
- ra  in  8  readback address.
- q  out  8  readback data.
- border, vpage, vconf, palsel, tsconf, tmpage, sgpage, hint_beg  out  8 each  active values.
- gx_offs, gy_offs  out  OFFS_W  graphics scroll.
- tx_offs, ty_offs  out  NLAYERS*OFFS_W  per-layer scroll, layer i at [i*OFFS_W +: OFFS_W].
- tgpage  out  NLAYERS*8  per-layer graphics page.
- vint_beg  out  9  VINT line.

Behaviour:
- Address map:
  - 00 border, 01 vpage, 02 vconf, 03 palsel, 04 tsconf, 05 tmpage, 06 sgpage, 07 hint_beg.
  - 08 vint_begl; 09 vint_begh: d[0] is the MSB, d[7:4] is vint_inc.
  - 0A/0B gx lo/hi; 0C/0D gy lo/hi.
  - 10+4i tx lo, 11+4i tx hi, 12+4i ty lo, 13+4i ty hi, for i < NLAYERS.
  - 20+i tgpage.
  - Unmapped addresses, and layers at or above NLAYERS, are ignored.
- Reset (res_n=0 at a clk edge; highest priority; applies to shadow and active copies):
  - vpage = 05, palsel = 0F, hint_beg = 01.
  - All other registers, vint_inc and q = 0.
- Immediate class (active equals shadow, updated the cycle after wr): border, tsconf, tmpage, sgpage, hint_beg. Y offsets also belong here when YLATCH=0.
- Line class (shadow on wr; active loads shadow on line_start_s): vpage, vconf, palsel, gx_offs, tx_offs, tgpage.
- Frame class (YLATCH=1 only): gy_offs and ty_offs load from shadow on int_start.
- Write and latch pulse in the same cycle: the shadow takes d; the active copy takes the pre-write shadow value. The new value becomes active at the next pulse.
- zborder_wr: border <= {active palsel[3:0], 0, d[2:0]}.
  - A same-cycle wr to address 00 wins.
- zvpage_wr: shadow and active vpage <= {000001, d[3], 1} in the same cycle.
  - Overrides line_start_s for the active copy.
  - A same-cycle wr to address 01 wins for the shadow copy.
- VINT auto-increment:
  - Priority: reset > wr 08/09 > int_start.
  - On int_start: s = vint_beg + vint_inc, computed 10 bits wide.
  - vint_beg <= (s >= VLINES) ? s - VLINES : s.
  - A written vint_beg at or above VLINES is held until the next int_start, then wraps by the same rule.
- Latency: every output is registered, one cycle after its triggering edge; nothing is combinational from the inputs.

Optional Feature:
- Macro: VIDEO_PORTS_READBACK_EN.
- Defined:
  - q <= shadow value at ra, one cycle latency, using the same map as writes.
  - vint_begh reads {vint_inc, 000, MSB}.
  - High-offset bytes read zero-extended.
  - Unmapped addresses read FF.
- Undefined: q is constant 00 and the readback mux is not built.

Test Plan:
- Reset: hold res_n=0 for 2 clocks, release -> vpage=05, palsel=0F, hint_beg=01, all other outputs 0, vint_beg=0.
- Line-class latch: wr wa=02 d=83 -> vconf stays 00 until line_start_s, then reads 83 the next cycle. Repeat with wr and line_start_s in the same cycle -> vconf keeps its old value until the following pulse.
- Per-layer scroll (NLAYERS=4, OFFS_W=10): wr wa=1C d=34, wr wa=1D d=02, line_start_s -> tx_offs[39:30]=234, layers 0..2 unchanged.
- VINT wrap (VLINES=320): write 08=3C, 09=F1 giving 316, inc 15 -> after int_start vint_beg=11. A concurrent int_start and wr 08 -> the write value wins.
- ZX writes: palsel active=0A, zborder_wr d=FF -> border=A7; zvpage_wr d=08 with concurrent line_start_s -> vpage=07 immediately.
- YLATCH=1: wr 0C=55 -> gy_offs stays 0 through line_start_s and becomes 055 after int_start. With the readback macro defined, ra=0C -> q=55 one cycle later.

Source files
------------

// File: rtl/video_ports_ml_if.sv
// CPU-side bus of the video parameter latch bank: addressed writes, ZX-compatible
// border/page strobes and the registered readback port.
interface video_ports_ml_if;
   logic [7:0] d;
   logic       wr;
   logic [7:0] wa;
   logic       zborder_wr;
   logic       zvpage_wr;
   logic [7:0] ra;
   logic [7:0] q;

   modport master (output d, wr, wa, zborder_wr, zvpage_wr, ra, input q);
   modport slave  (input d, wr, wa, zborder_wr, zvpage_wr, ra, output q);
endinterface

// File: rtl/video_ports_ml.sv
// TSConf video parameter latch bank: shadow registers written by the CPU, active copies
// latched at line/frame start. Readback mux is built only with VIDEO_PORTS_READBACK_EN.
module video_ports_ml #(
   parameter int NLAYERS = 2,
   parameter int OFFS_W  = 9,
   parameter int VLINES  = 320,
   parameter int YLATCH  = 0
) (
   input  logic                        clk,
   input  logic                        res_n,
   video_ports_ml_if.slave             bus,
   input  logic                        line_start_s,
   input  logic                        int_start,
   output logic [7:0]                  border,
   output logic [7:0]                  vpage,
   output logic [7:0]                  vconf,
   output logic [7:0]                  palsel,
   output logic [7:0]                  tsconf,
   output logic [7:0]                  tmpage,
   output logic [7:0]                  sgpage,
   output logic [7:0]                  hint_beg,
   output logic [OFFS_W-1:0]           gx_offs,
   output logic [OFFS_W-1:0]           gy_offs,
   output logic [NLAYERS*OFFS_W-1:0]   tx_offs,
   output logic [NLAYERS*OFFS_W-1:0]   ty_offs,
   output logic [NLAYERS*8-1:0]        tgpage,
   output logic [8:0]                  vint_beg
);

   localparam int HI_W = OFFS_W - 8;
   localparam int TW   = NLAYERS * OFFS_W;

   logic [7:0]          vpage_s, vconf_s, palsel_s;
   logic [OFFS_W-1:0]   gx_s, gy_s, gy_a;
   logic [TW-1:0]       tx_s, ty_s, ty_a;
   logic [NLAYERS*8-1:0] tg_s;
   logic [3:0]          vint_inc;
   logic [7:0]          zv_val;
   logic [9:0]          vint_sum, vint_wrap;
   logic [7:0]          q_r;

   assign zv_val    = {6'b000001, bus.d[3], 1'b1};
   assign vint_sum  = {1'b0, vint_beg} + {6'b000000, vint_inc};
   assign vint_wrap = (vint_sum >= 10'(VLINES)) ? vint_sum - 10'(VLINES) : vint_sum;

   // Without frame latching the Y offsets are visible straight from the shadow copy.
   assign gy_offs = (YLATCH != 0) ? gy_a : gy_s;
   assign ty_offs = (YLATCH != 0) ? ty_a : ty_s;

   always_ff @(posedge clk) begin
      if (!res_n) begin
         border   <= '0;
         vpage    <= 8'h05;
         vpage_s  <= 8'h05;
         vconf    <= '0;
         vconf_s  <= '0;
         palsel   <= 8'h0F;
         palsel_s <= 8'h0F;
         tsconf   <= '0;
         tmpage   <= '0;
         sgpage   <= '0;
         hint_beg <= 8'h01;
         vint_beg <= '0;
         vint_inc <= '0;
         gx_offs  <= '0;
         gx_s     <= '0;
         gy_s     <= '0;
         gy_a     <= '0;
         tx_offs  <= '0;
         tx_s     <= '0;
         ty_s     <= '0;
         ty_a     <= '0;
         tgpage   <= '0;
         tg_s     <= '0;
      end else begin
         if (line_start_s) begin
            vconf   <= vconf_s;
            palsel  <= palsel_s;
            gx_offs <= gx_s;
            tx_offs <= tx_s;
            tgpage  <= tg_s;
         end
         if (bus.zvpage_wr)
            vpage <= zv_val;
         else if (line_start_s)
            vpage <= vpage_s;
         if (YLATCH != 0 && int_start) begin
            gy_a <= gy_s;
            ty_a <= ty_s;
         end
         if (bus.zvpage_wr)
            vpage_s <= zv_val;
         if (bus.zborder_wr)
            border <= {palsel[3:0], 1'b0, bus.d[2:0]};
         if (int_start)
            vint_beg <= vint_wrap[8:0];

         // Addressed writes come last so they override the strobes and the VINT step.
         if (bus.wr) begin
            case (bus.wa)
               8'h00: border   <= bus.d;
               8'h01: vpage_s  <= bus.d;
               8'h02: vconf_s  <= bus.d;
               8'h03: palsel_s <= bus.d;
               8'h04: tsconf   <= bus.d;
               8'h05: tmpage   <= bus.d;
               8'h06: sgpage   <= bus.d;
               8'h07: hint_beg <= bus.d;
               8'h08: vint_beg <= {vint_beg[8], bus.d};
               8'h09: begin
                  vint_beg <= {bus.d[0], vint_beg[7:0]};
                  vint_inc <= bus.d[7:4];
               end
               8'h0A: gx_s[7:0]        <= bus.d;
               8'h0B: gx_s[OFFS_W-1:8] <= bus.d[HI_W-1:0];
               8'h0C: gy_s[7:0]        <= bus.d;
               8'h0D: gy_s[OFFS_W-1:8] <= bus.d[HI_W-1:0];
               default: ;
            endcase
            for (int i = 0; i < NLAYERS; i++) begin
               if (bus.wa == 8'(16 + 4*i)) tx_s[i*OFFS_W +: 8]    <= bus.d;
               if (bus.wa == 8'(17 + 4*i)) tx_s[i*OFFS_W+8 +: HI_W] <= bus.d[HI_W-1:0];
               if (bus.wa == 8'(18 + 4*i)) ty_s[i*OFFS_W +: 8]    <= bus.d;
               if (bus.wa == 8'(19 + 4*i)) ty_s[i*OFFS_W+8 +: HI_W] <= bus.d[HI_W-1:0];
               if (bus.wa == 8'(32 + i))   tg_s[i*8 +: 8]          <= bus.d;
            end
         end
      end
   end

`ifdef VIDEO_PORTS_READBACK_EN
   logic [7:0] rb;

   always_comb begin
      rb = 8'hFF;
      case (bus.ra)
         8'h00: rb = border;
         8'h01: rb = vpage_s;
         8'h02: rb = vconf_s;
         8'h03: rb = palsel_s;
         8'h04: rb = tsconf;
         8'h05: rb = tmpage;
         8'h06: rb = sgpage;
         8'h07: rb = hint_beg;
         8'h08: rb = vint_beg[7:0];
         8'h09: rb = {vint_inc, 3'b000, vint_beg[8]};
         8'h0A: rb = gx_s[7:0];
         8'h0B: rb = 8'(gx_s[OFFS_W-1:8]);
         8'h0C: rb = gy_s[7:0];
         8'h0D: rb = 8'(gy_s[OFFS_W-1:8]);
         default: ;
      endcase
      for (int i = 0; i < NLAYERS; i++) begin
         if (bus.ra == 8'(16 + 4*i)) rb = tx_s[i*OFFS_W +: 8];
         if (bus.ra == 8'(17 + 4*i)) rb = 8'(tx_s[i*OFFS_W+8 +: HI_W]);
         if (bus.ra == 8'(18 + 4*i)) rb = ty_s[i*OFFS_W +: 8];
         if (bus.ra == 8'(19 + 4*i)) rb = 8'(ty_s[i*OFFS_W+8 +: HI_W]);
         if (bus.ra == 8'(32 + i))   rb = tg_s[i*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!res_n) q_r <= '0;
      else        q_r <= rb;
   end
`else
   assign q_r = 8'h00;
`endif

   assign bus.q = q_r;

endmodule
